// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
//   Turns single register read/write commands into byte-level transactions
//   for an I2C master core. A write sends reg, [wdata hi], wdata lo in one
//   transaction. A read first writes the register index, then reads 1 or 2
//   bytes in a second transaction.
//
//   Build option: define I2C_SEQ_TIMEOUT_EN to build a per-transaction
//   watchdog. It aborts with rsp_error after TIMEOUT_CYCLES clk cycles spent
//   in one *_START/*_BUSY phase. When the macro is undefined, the sequencer
//   waits on m_ready indefinitely.
//
// Ports
//   clk, rst                 system clock, synchronous active-low reset
//   cmd_valid / cmd_ready    command handshake (cmd_ready only in IDLE)
//   cmd_rw                   1 = register read, 0 = register write
//   cmd_dev, cmd_reg         7-bit device address, 8-bit register index
//   cmd_wdata, cmd_two       write data (MSB byte first), 1 or 2 data bytes
//   rsp_valid                one-cycle completion pulse
//   rsp_data, rsp_error      read result and error flag
//   m_start, m_read_nwrite   master transaction request and direction
//   m_addr, m_data_size      master slave address and byte count
//   m_data_i                 byte to the master for writes
//   m_ready                  master idle
//   m_data_request           master wants the next write byte (pulse)
//   m_data_available         m_data_o holds a received byte (pulse)
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev,
  input  logic [7:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  input  logic        cmd_two,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_error,
  output logic        m_start,
  output logic        m_read_nwrite,
  output logic [6:0]  m_addr,
  output logic [7:0]  m_data_i,
  output logic [2:0]  m_data_size,
  input  logic        m_ready,
  input  logic        m_data_request,
  input  logic        m_data_available,
  input  logic [7:0]  m_data_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_START = 3'd1,
    WR_BUSY  = 3'd2,
    RA_START = 3'd3,
    RA_BUSY  = 3'd4,
    RD_START = 3'd5,
    RD_BUSY  = 3'd6,
    RESP     = 3'd7
  } state_t;

  state_t      state_q, state_d;

  // Latched command fields; m_addr_q doubles as the device-address latch.
  logic [7:0]  reg_q, reg_d;
  logic [15:0] wdata_q, wdata_d;
  logic        two_q, two_d;

  // Write byte index in the write phases, received byte count in RD_BUSY.
  logic [1:0]  idx_q, idx_d;

  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;
  logic        m_start_q, m_start_d;
  logic        m_rnw_q, m_rnw_d;
  logic [6:0]  m_addr_q, m_addr_d;
  logic [7:0]  m_data_i_q, m_data_i_d;
  logic [2:0]  m_size_q, m_size_d;

  logic        in_txn;
  logic        tmo_hit;

  assign in_txn = (state_q inside {WR_START, WR_BUSY, RA_START, RA_BUSY, RD_START, RD_BUSY});

  // Byte order for register writes: reg, [wdata hi], wdata lo.
  function automatic logic [7:0] tx_byte(input logic [1:0]  idx,
                                         input logic [7:0]  rg,
                                         input logic [15:0] wd,
                                         input logic        two);
    logic [7:0] b;
    case (idx)
      2'd0:    b = rg;
      2'd1:    b = two ? wd[15:8] : wd[7:0];
      default: b = wd[7:0];
    endcase
    return b;
  endfunction

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit = in_txn && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if ((state_d inside {WR_START, RA_START, RD_START}) && (state_d != state_q)) begin
      tmo_d = '0;
    end else if (in_txn) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  logic [31:0] timeout_unused;

  assign tmo_hit        = 1'b0;
  // TIMEOUT_CYCLES only matters when the watchdog is built.
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_comb begin
    logic [1:0] last_idx;
    logic [1:0] idx_adv;
    logic [1:0] rx_expect;

    state_d     = state_q;
    reg_d       = reg_q;
    wdata_d     = wdata_q;
    two_d       = two_q;
    idx_d       = idx_q;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = 1'b0;
    m_rnw_d     = m_rnw_q;
    m_addr_d    = m_addr_q;
    m_data_i_d  = m_data_i_q;
    m_size_d    = m_size_q;

    // Register-address phase of a read sends only byte 0.
    last_idx  = (state_q == WR_BUSY) ? (two_q ? 2'd2 : 2'd1) : 2'd0;
    idx_adv   = (idx_q >= last_idx) ? last_idx : idx_q + 2'd1;
    rx_expect = two_q ? 2'd2 : 2'd1;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          reg_d      = cmd_reg;
          wdata_d    = cmd_wdata;
          two_d      = cmd_two;
          idx_d      = '0;
          rsp_data_d = '0;
          m_addr_d   = cmd_dev;
          m_data_i_d = cmd_reg;
          m_rnw_d    = 1'b0;
          if (cmd_rw) begin
            state_d  = RA_START;
            m_size_d = 3'd1;
          end else begin
            state_d  = WR_START;
            m_size_d = cmd_two ? 3'd3 : 3'd2;
          end
        end
      end

      WR_START: if (!m_ready) state_d = WR_BUSY;
      RA_START: if (!m_ready) state_d = RA_BUSY;
      RD_START: if (!m_ready) state_d = RD_BUSY;

      WR_BUSY: begin
        if (m_data_request) begin
          idx_d      = idx_adv;
          m_data_i_d = tx_byte(idx_adv, reg_q, wdata_q, two_q);
        end
        if (m_ready) begin
          state_d = RESP;
        end
      end

      RA_BUSY: begin
        if (m_data_request) begin
          idx_d      = idx_adv;
          m_data_i_d = tx_byte(idx_adv, reg_q, wdata_q, two_q);
        end
        if (m_ready) begin
          state_d  = RD_START;
          idx_d    = '0;
          m_rnw_d  = 1'b1;
          m_size_d = two_q ? 3'd2 : 3'd1;
        end
      end

      RD_BUSY: begin
        if (m_data_available && (idx_q < rx_expect)) begin
          rsp_data_d = {rsp_data_q[7:0], m_data_o};
          idx_d      = idx_q + 2'd1;
        end
        // Fewer bytes than requested when the master goes idle is a short read.
        if (m_ready) begin
          state_d     = RESP;
          rsp_error_d = (idx_d < rx_expect);
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d     = RESP;
      rsp_error_d = 1'b1;
    end

    // Status outputs are decoded from the next state so they register in step with it.
    m_start_d   = (state_d inside {WR_START, RA_START, RD_START});
    rsp_valid_d = (state_d == RESP);
    cmd_ready_d = (state_d == IDLE);
    if (state_d != RESP) begin
      rsp_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      reg_q       <= '0;
      wdata_q     <= '0;
      two_q       <= 1'b0;
      idx_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= 1'b0;
      m_start_q   <= 1'b0;
      m_rnw_q     <= 1'b0;
      m_addr_q    <= '0;
      m_data_i_q  <= '0;
      m_size_q    <= '0;
    end else begin
      state_q     <= state_d;
      reg_q       <= reg_d;
      wdata_q     <= wdata_d;
      two_q       <= two_d;
      idx_q       <= idx_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      m_start_q   <= m_start_d;
      m_rnw_q     <= m_rnw_d;
      m_addr_q    <= m_addr_d;
      m_data_i_q  <= m_data_i_d;
      m_size_q    <= m_size_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign m_start       = m_start_q;
  assign m_read_nwrite = m_rnw_q;
  assign m_addr        = m_addr_q;
  assign m_data_i      = m_data_i_q;
  assign m_data_size   = m_size_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Testbench for i2c_reg_sequencer: directed commands with a behavioural I2C
// master responder. Expected master transactions, write bytes and responses
// are queued at issue time and checked by independent monitors.
// With I2C_SEQ_TIMEOUT_EN defined, the watchdog abort path is exercised.
// Otherwise, the bench checks that a stalled master is waited on indefinitely.
module tb_i2c_reg_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [6:0]  cmd_dev;
  logic [7:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        cmd_two;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic        m_start;
  logic        m_read_nwrite;
  logic [6:0]  m_addr;
  logic [7:0]  m_data_i;
  logic [2:0]  m_data_size;
  logic        m_ready;
  logic        m_data_request;
  logic        m_data_available;
  logic [7:0]  m_data_o;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.TIMEOUT_CYCLES(50)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_rw           (cmd_rw),
    .cmd_dev          (cmd_dev),
    .cmd_reg          (cmd_reg),
    .cmd_wdata        (cmd_wdata),
    .cmd_two          (cmd_two),
    .rsp_valid        (rsp_valid),
    .rsp_data         (rsp_data),
    .rsp_error        (rsp_error),
    .m_start          (m_start),
    .m_read_nwrite    (m_read_nwrite),
    .m_addr           (m_addr),
    .m_data_i         (m_data_i),
    .m_data_size      (m_data_size),
    .m_ready          (m_ready),
    .m_data_request   (m_data_request),
    .m_data_available (m_data_available),
    .m_data_o         (m_data_o)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  typedef struct packed {
    logic       rnw;
    logic [6:0] addr;
    logic [2:0] size;
  } txn_t;

  rsp_t       exp_rsp[$];
  txn_t       exp_txn[$];
  logic [7:0] exp_byte[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // ---------------- monitors ----------------
  rsp_t       mon_rsp;
  txn_t       mon_txn;
  logic [7:0] mon_byte;
  logic       mstart_prev = 1'b0;
  logic       req_s = 1'b0;

  always @(posedge clk) req_s <= m_data_request;

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        miss("rsp_unexpected", $sformatf("got rsp data=0x%0h err=%0b, expected none", rsp_data, rsp_error));
      end else begin
        mon_rsp = exp_rsp.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(mon_rsp.data));
        check("rsp_error", 32'(rsp_error), 32'(mon_rsp.err));
      end
    end
    if (m_start && !mstart_prev) begin
      if (exp_txn.size() == 0) begin
        miss("txn_unexpected", $sformatf("got m_start addr=0x%0h, expected none", m_addr));
      end else begin
        mon_txn = exp_txn.pop_front();
        check("txn_rnw", 32'(m_read_nwrite), 32'(mon_txn.rnw));
        check("txn_addr", 32'(m_addr), 32'(mon_txn.addr));
        check("txn_size", 32'(m_data_size), 32'(mon_txn.size));
      end
    end
    if ((m_start && !mstart_prev && !m_read_nwrite) || req_s) begin
      if (exp_byte.size() == 0) begin
        miss("byte_unexpected", $sformatf("got byte 0x%0h, expected none", m_data_i));
      end else begin
        mon_byte = exp_byte.pop_front();
        check("wr_byte", 32'(m_data_i), 32'(mon_byte));
      end
    end
    mstart_prev = m_start;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wr_byte_model(input int i, input logic [7:0] rg,
                                               input logic [15:0] wd, input logic two);
    int last;
    int j;
    last = two ? 2 : 1;
    j = (i > last) ? last : i;
    if (j == 0) return rg;
    if (j == 1) return two ? wd[15:8] : wd[7:0];
    return wd[7:0];
  endfunction

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [15:0] wd, input logic two, input int hold);
    int k;
    cmd_rw    = rw;
    cmd_dev   = dev;
    cmd_reg   = rg;
    cmd_wdata = wd;
    cmd_two   = two;
    cmd_valid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (cmd_ready) break;
      k++;
    end
    if (k == 50) begin
      miss("cmd_ready_wait", "got cmd_ready=0 for 50 cycles, expected 1");
      cmd_valid = 1'b0;
      return;
    end
    tick();
    for (int i = 0; i < hold; i++) tick();
    cmd_valid = 1'b0;
  endtask

  // One master transaction phase: accept start, serve requests / return bytes, go idle.
  task automatic serve(input int nreq, input int navail, input logic [7:0] d0, input logic [7:0] d1);
    int k;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (m_start) break;
      k++;
    end
    if (k == 40) begin
      miss("m_start_wait", "got m_start=0 for 40 cycles, expected 1");
      return;
    end
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("m_start_held", 32'(m_start), 32'd1);
    tick();
    @(negedge clk);
    check("m_start_fall", 32'(m_start), 32'd0);
    for (int i = 0; i < nreq; i++) begin
      tick();
      m_data_request = 1'b1;
      tick();
      m_data_request = 1'b0;
    end
    for (int i = 0; i < navail; i++) begin
      tick();
      m_data_o         = (i == 0) ? d0 : d1;
      m_data_available = 1'b1;
      tick();
      m_data_available = 1'b0;
    end
    tick();
    m_ready = 1'b1;
    tick();
  endtask

  task automatic do_write(input logic [6:0] dev, input logic [7:0] rg, input logic [15:0] wd,
                          input logic two, input int nreq, input int hold);
    exp_txn.push_back('{rnw: 1'b0, addr: dev, size: two ? 3'd3 : 3'd2});
    for (int i = 0; i <= nreq; i++) exp_byte.push_back(wr_byte_model(i, rg, wd, two));
    exp_rsp.push_back('{data: 16'h0000, err: 1'b0});
    send(1'b0, dev, rg, wd, two, hold);
    serve(nreq, 0, 8'h00, 8'h00);
  endtask

  task automatic do_read(input logic [6:0] dev, input logic [7:0] rg, input logic two,
                         input int navail, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [15:0] exp_data, input logic exp_err);
    exp_txn.push_back('{rnw: 1'b0, addr: dev, size: 3'd1});
    exp_byte.push_back(rg);
    exp_txn.push_back('{rnw: 1'b1, addr: dev, size: two ? 3'd2 : 3'd1});
    exp_rsp.push_back('{data: exp_data, err: exp_err});
    send(1'b1, dev, rg, 16'h0000, two, 0);
    serve(0, 0, 8'h00, 8'h00);
    serve(0, navail, d0, d1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst              = 1'b0;
    cmd_valid        = 1'b0;
    cmd_rw           = 1'b0;
    cmd_dev          = '0;
    cmd_reg          = '0;
    cmd_wdata        = '0;
    cmd_two          = 1'b0;
    m_ready          = 1'b1;
    m_data_request   = 1'b0;
    m_data_available = 1'b0;
    m_data_o         = '0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_outputs", {m_start, m_read_nwrite, m_addr, m_data_i, m_data_size,
                            rsp_valid, rsp_error}, 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Basic one-byte write: bytes 0x10, 0xAB.
    do_write(7'h55, 8'h10, 16'h00AB, 1'b0, 1, 0);
    // Two-byte read returning 0xCE, 0x13.
    do_read(7'h55, 8'h20, 1'b1, 2, 8'hCE, 8'h13, 16'hCE13, 1'b0);
    // cmd_valid held 5 cycles past acceptance: only one transaction expected.
    do_write(7'h33, 8'h01, 16'hBEEF, 1'b1, 2, 5);
    // Extra requests saturate on the last byte.
    do_write(7'h12, 8'h02, 16'h1234, 1'b1, 3, 0);
    do_write(7'h7F, 8'hFE, 16'h5A3C, 1'b0, 2, 0);
    // Short read, extra data pulses, single byte read, zero-byte short read.
    do_read(7'h41, 8'h05, 1'b1, 1, 8'h7E, 8'h00, 16'h007E, 1'b1);
    do_read(7'h41, 8'h06, 1'b0, 2, 8'h11, 8'h22, 16'h0011, 1'b0);
    do_read(7'h7F, 8'hFF, 1'b0, 1, 8'h80, 8'h00, 16'h0080, 1'b0);
    do_read(7'h01, 8'h00, 1'b0, 0, 8'h00, 8'h00, 16'h0000, 1'b1);

    // Reset while in RD_BUSY after one received byte.
    exp_txn.push_back('{rnw: 1'b0, addr: 7'h2B, size: 3'd1});
    exp_byte.push_back(8'h30);
    exp_txn.push_back('{rnw: 1'b1, addr: 7'h2B, size: 3'd2});
    send(1'b1, 7'h2B, 8'h30, 16'h0000, 1'b1, 0);
    serve(0, 0, 8'h00, 8'h00);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (m_start) break;
      k++;
    end
    if (k == 40) miss("rd_start_wait", "got m_start=0 for 40 cycles, expected 1");
    tick();
    m_ready = 1'b0;
    tick();
    m_data_o         = 8'h5A;
    m_data_available = 1'b1;
    tick();
    m_data_available = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("midreset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midreset_outputs", {m_start, m_read_nwrite, m_addr, m_data_i, m_data_size,
                               rsp_valid, rsp_error}, 32'd0);
    check("midreset_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    m_ready = 1'b1;
    tick();
    do_write(7'h55, 8'h10, 16'h00AB, 1'b0, 1, 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // Master never goes idle: abort 50 cycles after entering WR_START.
    exp_txn.push_back('{rnw: 1'b0, addr: 7'h2A, size: 3'd2});
    exp_byte.push_back(8'h44);
    exp_rsp.push_back('{data: 16'h0000, err: 1'b1});
    m_ready = 1'b0;
    send(1'b0, 7'h2A, 8'h44, 16'h0099, 1'b0, 0);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      if (rsp_valid) break;
      k++;
    end
    check("timeout_latency", 32'(k), 32'd50);
    @(negedge clk);
    check("timeout_idle", 32'(cmd_ready), 32'd1);
    tick();
    m_ready = 1'b1;
`else
    // Without the watchdog a stalled master is waited on indefinitely.
    exp_txn.push_back('{rnw: 1'b0, addr: 7'h2A, size: 3'd2});
    exp_byte.push_back(8'h44);
    m_ready = 1'b0;
    send(1'b0, 7'h2A, 8'h44, 16'h0099, 1'b0, 0);
    k = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    check("no_timeout", 32'(k), 32'd0);
    exp_rsp.push_back('{data: 16'h0000, err: 1'b0});
    tick();
    m_ready = 1'b1;
`endif

    repeat (6) tick();
    check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
    check("txn_queue_empty", 32'(exp_txn.size()), 32'd0);
    check("byte_queue_empty", 32'(exp_byte.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
